// File: rtl/hex_seq_pkg.sv
// Shared definitions for the hex display sequencer.
//   state_t    : sequencer FSM states
//   SEG_TABLE  : active-high gfedcba patterns for hex digits 0..F
//   SEG_BLANK  : active-high pattern with every segment off
//   lz_mask()  : leading-zero blank mask for a four-digit value
package hex_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Digit i (3..1) is a leading zero when it and every digit above it are
  // zero. Digit 0 always shows, so a value of zero still displays "0".
  function automatic logic [3:0] lz_mask(input logic [15:0] digits);
    logic [3:0] m;
    m[3] = (digits[15:12] == 4'h0);
    m[2] = m[3] && (digits[11:8] == 4'h0);
    m[1] = m[2] && (digits[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/hex7seg_encoder.sv
// Combinational seven-segment encoder.
//   nibble     : hex value to display
//   blank      : 1 = all segments off
//   active_low : 1 = a lit segment is driven as logic 0
//   seg        : gfedcba pattern (bit 0 = segment a)
module hex7seg_encoder
  import hex_seq_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       active_low,
  output logic [6:0] seg
);

  logic [6:0] seg_high;

  always_comb begin
    seg_high = blank ? SEG_BLANK : SEG_TABLE[nibble];
    // Inverting the blank pattern too gives all-off for either polarity.
    seg      = active_low ? ~seg_high : seg_high;
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// Writes four hex digits, one per cycle, to four memory-mapped 7-segment
// display ports, then pulses done.
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : request, sampled only while idle
//   digits_in[15:0]   : four nibbles, [3:0] = rightmost digit 0
//   blank_in[3:0]     : per-digit force-blank mask
//   busy, done        : request in service / one-cycle completion pulse
//   hex_chipselect    : one-hot port select, bit i = digit i
//   hex_address       : port register address, always 0
//   hex_write_n       : active-low write strobe
//   hex_writedata     : gfedcba segment pattern
module hex_display_sequencer
  import hex_seq_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blank_in,
  output logic        busy,
  output logic        done,
  output logic [3:0]  hex_chipselect,
  output logic [1:0]  hex_address,
  output logic        hex_write_n,
  output logic [6:0]  hex_writedata
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  blank_q, blank_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  cs_q, cs_d;
  logic        write_n_q, write_n_d;
  logic [6:0]  wdata_q, wdata_d;
  logic [1:0]  addr_q;

  // Source of the digit shown next cycle: the live inputs on the accepting
  // edge, the captured copy afterwards.
  logic [15:0] src_digits;
  logic [3:0]  src_blank;
  logic [3:0]  blank_mask;
  logic [3:0]  sel_nibble;
  logic        sel_blank;
  logic [6:0]  seg_pattern;

  // Outputs are registered, so everything below is computed for the *next*
  // cycle: the first write appears in the cycle right after start is taken.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    src_digits = digits_q;
    src_blank  = blank_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WRITE;
          idx_d      = 2'd0;
          digits_d   = digits_in;
          blank_d    = blank_in;
          src_digits = digits_in;
          src_blank  = blank_in;
        end
      end
      WRITE: begin
        if (idx_q == 2'd3) begin
          state_d = DONE;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    blank_mask = src_blank | (LZ_BLANK ? lz_mask(src_digits) : 4'b0000);
    sel_nibble = src_digits[{idx_d, 2'b00} +: 4];
    sel_blank  = blank_mask[idx_d];

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    cs_d      = (state_d == WRITE) ? (4'b0001 << idx_d) : 4'b0000;
    write_n_d = (state_d != WRITE);
    wdata_d   = (state_d == WRITE) ? seg_pattern : 7'h00;
  end

  hex7seg_encoder u_encoder (
    .nibble     (sel_nibble),
    .blank      (sel_blank),
    .active_low (SEG_ACTIVE_LOW),
    .seg        (seg_pattern)
  );

  // Reset clears the FSM and all outputs at once, which also aborts a
  // sequence in flight: nothing resumes after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      digits_q  <= 16'h0000;
      blank_q   <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 4'b0000;
      write_n_q <= 1'b1;
      wdata_q   <= 7'h00;
      addr_q    <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      idx_q     <= idx_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      write_n_q <= write_n_d;
      wdata_q   <= wdata_d;
      addr_q    <= 2'b00;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign hex_chipselect = cs_q;
  assign hex_address    = addr_q;
  assign hex_write_n    = write_n_q;
  assign hex_writedata  = wdata_q;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Scoreboard bench: two sequencers (default parameters, and active-high with
// leading-zero blanking) share stimulus. A reference model pushes expected
// writes and done pulses per accepted request; a monitor pops and compares
// whenever a DUT drives its display ports.
module tb_hex_display_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;

  logic       busy_a, done_a, wn_a, busy_b, done_b, wn_b;
  logic [3:0] cs_a, cs_b;
  logic [1:0] ad_a, ad_b;
  logic [6:0] wd_a, wd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_display_sequencer dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .digits_in(digits_in),
    .blank_in(blank_in), .busy(busy_a), .done(done_a),
    .hex_chipselect(cs_a), .hex_address(ad_a), .hex_write_n(wn_a),
    .hex_writedata(wd_a)
  );

  hex_display_sequencer #(.SEG_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .digits_in(digits_in),
    .blank_in(blank_in), .busy(busy_b), .done(done_b),
    .hex_chipselect(cs_b), .hex_address(ad_b), .hex_write_n(wn_b),
    .hex_writedata(wd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        is_done;
    logic [3:0]  cs;
    logic [6:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [6:0] seg_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int unsigned cyc = 0;
  int          busy_cnt = 0;

  function automatic logic [6:0] exp_seg(input logic [3:0] v, input bit blanked, input bit act_low);
    logic [6:0] p;
    p = blanked ? 7'h00 : seg_tbl[v];
    return act_low ? ~p : p;
  endfunction

  task automatic push_req(input logic [15:0] d, input logic [3:0] b, input int unsigned n);
    for (int which = 0; which < 2; which++) begin
      bit         act_low = (which == 0);
      bit         lz      = (which == 1);
      bit         above_zero = 1'b1;
      logic [3:0] blanked;
      exp_t       e;
      for (int i = 3; i >= 0; i--) begin
        blanked[i] = b[i] | (lz && i > 0 && above_zero && d[i*4 +: 4] == 4'h0);
        if (d[i*4 +: 4] != 4'h0) above_zero = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        e.is_done = 1'b0;
        e.cs      = 4'(1 << i);
        e.data    = exp_seg(d[i*4 +: 4], blanked[i], act_low);
        e.cyc     = n + 32'(i);
        if (which == 0) q_a.push_back(e); else q_b.push_back(e);
      end
      e.is_done = 1'b1;
      e.cs      = 4'b0000;
      e.data    = 7'h00;
      e.cyc     = n + 4;
      if (which == 0) q_a.push_back(e); else q_b.push_back(e);
    end
  endtask

  // A request occupies four write cycles plus the done cycle; one idle cycle
  // follows before the next start can be taken.
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      q_a.delete();
      q_b.delete();
      busy_cnt = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end else if (start) begin
      push_req(digits_in, blank_in, cyc);
      busy_cnt = 5;
    end
  end

  // ---------------- monitor ----------------
  function automatic int q_size(input int which);
    return (which == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic exp_t q_pop(input int which);
    return (which == 0) ? q_a.pop_front() : q_b.pop_front();
  endfunction

  function automatic exp_t q_front(input int which);
    return (which == 0) ? q_a[0] : q_b[0];
  endfunction

  task automatic mon(input int which, input logic [3:0] cs, input logic wn,
                     input logic [6:0] wd, input logic bz, input logic dn,
                     input logic [1:0] ad);
    string tag = (which == 0) ? "a" : "b";
    exp_t  e;
    check({tag, "_busy"}, 32'(bz), 32'(reset_n && busy_cnt > 0));
    check({tag, "_address"}, 32'(ad), 32'd0);
    while (q_size(which) > 0 && q_front(which).cyc < cyc) begin
      e = q_pop(which);
      check({tag, "_missed_output_cycle"}, 32'(cyc), e.cyc);
    end
    if (!wn || dn) begin
      if (q_size(which) == 0) begin
        check({tag, "_unexpected_cs"}, 32'(cs), 32'd0);
        check({tag, "_unexpected_write_n"}, 32'(wn), 32'd1);
        check({tag, "_unexpected_done"}, 32'(dn), 32'd0);
      end else begin
        e = q_pop(which);
        check({tag, "_cycle"}, 32'(cyc), e.cyc);
        if (e.is_done) begin
          check({tag, "_done"}, 32'(dn), 32'd1);
          check({tag, "_done_write_n"}, 32'(wn), 32'd1);
          check({tag, "_done_cs"}, 32'(cs), 32'd0);
        end else begin
          check({tag, "_cs"}, 32'(cs), 32'(e.cs));
          check({tag, "_data"}, 32'(wd), 32'(e.data));
          check({tag, "_write_done"}, 32'(dn), 32'd0);
        end
      end
    end else begin
      check({tag, "_idle_cs"}, 32'(cs), 32'd0);
      check({tag, "_idle_data"}, 32'(wd), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, cs_a, wn_a, wd_a, busy_a, done_a, ad_a);
    mon(1, cs_b, wn_b, wd_b, busy_b, done_b, ad_b);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic [15:0] d, input logic [3:0] b);
    @(posedge clk);
    #2;
    start     = s;
    digits_in = d;
    blank_in  = b;
  endtask

  // Inputs are scrambled while the request is in flight; only the captured
  // values may appear on the ports.
  task automatic request(input logic [15:0] d, input logic [3:0] b);
    drive(1'b1, d, b);
    for (int i = 0; i < 7; i++) drive(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_cs_a"}, 32'(cs_a), 32'd0);
    check({tag, "_rst_wn_a"}, 32'(wn_a), 32'd1);
    check({tag, "_rst_wd_a"}, 32'(wd_a), 32'd0);
    check({tag, "_rst_busy_a"}, 32'(busy_a), 32'd0);
    check({tag, "_rst_done_a"}, 32'(done_a), 32'd0);
    check({tag, "_rst_cs_b"}, 32'(cs_b), 32'd0);
    check({tag, "_rst_wn_b"}, 32'(wn_b), 32'd1);
    check({tag, "_rst_wd_b"}, 32'(wd_b), 32'd0);
    check({tag, "_rst_busy_b"}, 32'(busy_b), 32'd0);
    check({tag, "_rst_done_b"}, 32'(done_b), 32'd0);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int i = 0; i < 4; i++)
      d[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    bit found;
    reset_n   = 1'b0;
    start     = 1'b0;
    digits_in = 16'h0000;
    blank_in  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("init");
    check("init_address_a", 32'(ad_a), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Digit 0 is the low nibble, so 16'h1234 shows 4,3,2,1 on ports 0..3.
    request(16'h1234, 4'b0000);
    request(16'h0050, 4'b0000);
    request(16'h0000, 4'b0000);
    request(16'h8888, 4'b1010);
    request(16'hFEDC, 4'b0000);
    request(16'hBA90, 4'b0001);

    // Start held high: back-to-back sequences with one idle cycle between.
    for (int i = 0; i < 10; i++) drive(1'b1, 16'h0705, 4'b0000);
    for (int i = 0; i < 8; i++) drive(1'b0, 16'h0000, 4'b0000);

    // Reset during the third write aborts the sequence.
    drive(1'b1, 16'h6543, 4'b0000);
    drive(1'b0, 16'h6543, 4'b0000);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1;
      if (cs_a == 4'b0100) found = 1'b1;
    end
    check("third_write_seen", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    request(16'h00A7, 4'b0000);

    // Random traffic, including start pulses while busy.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 2) == 0), rand_digits(),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    for (int i = 0; i < 10; i++) drive(1'b0, 16'h0000, 4'b0000);

    @(posedge clk);
    #3;
    check("drain_a", 32'(q_a.size()), 32'd0);
    check("drain_b", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
